// File: rtl/srio_stream_monitor.sv
// Passive AXI4-Stream tap for an sRIO logical port: packet/beat statistics, a header-record
// FIFO (first-word-fall-through) and sticky protocol-violation / stall flags.
module srio_stream_monitor #(
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int STALL_LIMIT = 1024,
    parameter int LEN_W       = 16
) (
    input  logic                log_clk,
    input  logic                log_rst,
    input  logic                tvalid,
    input  logic                tready,
    input  logic                tlast,
    input  logic [DATA_W-1:0]   tdata,
    input  logic [DATA_W/8-1:0] tkeep,
    input  logic [31:0]         tuser,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    beat_count,
    output logic [15:0]         ftype_seen,
    output logic                hdr_valid,
    input  logic                hdr_ready,
    output logic [63:0]         hdr_data,
    output logic [31:0]         hdr_tuser,
    output logic [LEN_W-1:0]    hdr_len,
    output logic                hdr_overflow,
    output logic                err_hold,
    output logic                err_stall
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SC_W  = $clog2(STALL_LIMIT + 1);
    localparam int REC_W = 64 + 32 + LEN_W;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t             state, state_next;
    logic [63:0]        hdr_q, hdr_next;
    logic [31:0]        user_q, user_next;
    logic [LEN_W-1:0]   len_q, len_next;
    logic               push;

    logic               hs, stall, header_beat;

    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic               full, pop, push_ok;

    logic               stall_q, tlast_q;
    logic [DATA_W-1:0]  tdata_q;
    logic [DATA_W/8-1:0] tkeep_q;
    logic [31:0]        tuser_q;
    logic [SC_W-1:0]    stall_cnt;

    assign hs          = tvalid && tready;
    assign stall       = tvalid && !tready;
    assign header_beat = (state == IDLE) && hs;

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state  <= IDLE;
            hdr_q  <= '0;
            user_q <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_next;
            hdr_q  <= hdr_next;
            user_q <= user_next;
            len_q  <= len_next;
        end
    end

    // The record pushed on tlast is built from the next-state values, so a single-beat
    // packet takes its header straight from the bus.
    always_comb begin
        state_next = state;
        hdr_next   = hdr_q;
        user_next  = user_q;
        len_next   = len_q;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    hdr_next  = tdata[DATA_W-1 -: 64];
                    user_next = tuser;
                    len_next  = LEN_W'(1);
                    if (tlast) push = 1'b1;
                    else       state_next = IN_PKT;
                end
            end
            IN_PKT: begin
                if (hs) begin
                    len_next = (len_q == '1) ? len_q : len_q + LEN_W'(1);
                    if (tlast) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge log_clk) begin
        if (log_rst || clr_stats) begin
            pkt_count  <= '0;
            beat_count <= '0;
            ftype_seen <= '0;
        end else begin
            if (hs && tlast && pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
            if (hs && beat_count != '1)         beat_count <= beat_count + CNT_W'(1);
            if (header_beat)                    ftype_seen[tdata[DATA_W-9 -: 4]] <= 1'b1;
        end
    end

    assign full    = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign pop     = hdr_valid && hdr_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge log_clk) begin
        if (push_ok) mem[wr_ptr] <= {hdr_next, user_next, len_next};
    end

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign hdr_valid = (fifo_cnt != '0);
    assign {hdr_data, hdr_tuser, hdr_len} = hdr_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            stall_q <= 1'b0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            tkeep_q <= '0;
            tuser_q <= '0;
        end else begin
            stall_q <= stall;
            tdata_q <= tdata;
            tlast_q <= tlast;
            tkeep_q <= tkeep;
            tuser_q <= tuser;
        end
    end

    // Stall counter parks at the limit so err_stall fires exactly once per long stall.
    always_ff @(posedge log_clk) begin
        if (log_rst)                     stall_cnt <= '0;
        else if (!stall)                 stall_cnt <= '0;
        else if (stall_cnt != SC_W'(STALL_LIMIT)) stall_cnt <= stall_cnt + SC_W'(1);
    end

    always_ff @(posedge log_clk) begin
        if (log_rst || clr_stats) begin
            hdr_overflow <= 1'b0;
            err_hold     <= 1'b0;
            err_stall    <= 1'b0;
        end else begin
            if (push && full && !pop) hdr_overflow <= 1'b1;
            if (stall_q && (!tvalid || tdata != tdata_q || tlast != tlast_q ||
                            tkeep != tkeep_q || tuser != tuser_q))
                err_hold <= 1'b1;
            if (stall && stall_cnt >= SC_W'(STALL_LIMIT - 1)) err_stall <= 1'b1;
        end
    end

endmodule

// File: tb/tb_srio_stream_monitor.sv
// Scoreboard bench for srio_stream_monitor: expected header records are queued as packets
// are driven and compared as they are popped from the DUT FIFO.
module tb_srio_stream_monitor;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;
    localparam int LEN_W  = 16;

    typedef struct {
        logic [63:0]      d;
        logic [31:0]      u;
        logic [LEN_W-1:0] l;
    } rec_t;

    logic                log_clk = 1'b0;
    logic                log_rst;
    logic                tvalid, tready, tlast, clr_stats, hdr_ready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [31:0]         tuser;
    logic [CNT_W-1:0]    pkt_count, beat_count;
    logic [15:0]         ftype_seen;
    logic                hdr_valid, hdr_overflow, err_hold, err_stall;
    logic [63:0]         hdr_data;
    logic [31:0]         hdr_tuser;
    logic [LEN_W-1:0]    hdr_len;

    rec_t sb[$];
    int   checks = 0;
    int   passes = 0;

    srio_stream_monitor #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(8), .STALL_LIMIT(16), .LEN_W(LEN_W)
    ) dut (
        .log_clk(log_clk), .log_rst(log_rst), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .tdata(tdata), .tkeep(tkeep), .tuser(tuser), .clr_stats(clr_stats),
        .pkt_count(pkt_count), .beat_count(beat_count), .ftype_seen(ftype_seen),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_tuser(hdr_tuser),
        .hdr_len(hdr_len), .hdr_overflow(hdr_overflow), .err_hold(err_hold), .err_stall(err_stall)
    );

    always #5 log_clk = ~log_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic do_reset();
        log_rst = 1'b1; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tdata = '0;
        tkeep = '1; tuser = '0; clr_stats = 1'b0; hdr_ready = 1'b0;
        tick(); tick();
        log_rst = 1'b0;
        sb.delete();
    endtask

    // Drives one packet with tready high; the header FTYPE sits at tdata[55:52].
    task automatic send_pkt(input int nbeats, input logic [3:0] ftype, input logic [31:0] user,
                            input bit expect_rec);
        logic [63:0] hdr;
        rec_t r;
        hdr = {$urandom, $urandom};
        hdr[55:52] = ftype;
        for (int b = 0; b < nbeats; b++) begin
            tvalid = 1'b1; tready = 1'b1;
            tlast  = (b == nbeats - 1);
            tdata  = (b == 0) ? hdr : {$urandom, $urandom};
            tuser  = (b == 0) ? user : ~user;
            if (tlast && expect_rec) begin
                r.d = hdr; r.u = user; r.l = LEN_W'(nbeats);
                sb.push_back(r);
            end
            tick();
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic drain(input string tag);
        rec_t r;
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 32) begin
            guard++;
            r = sb.pop_front();
            checks++;
            if (hdr_valid !== 1'b1) begin
                $display("[TB] FAIL %s_valid: got %b want 1", tag, hdr_valid);
                sb.delete();
                break;
            end else passes++;
            checks++;
            if (hdr_data !== r.d || hdr_tuser !== r.u || hdr_len !== r.l)
                $display("[TB] FAIL %s_rec: got %h/%h/%0d want %h/%h/%0d",
                         tag, hdr_data, hdr_tuser, hdr_len, r.d, r.u, r.l);
            else passes++;
            hdr_ready = 1'b1;
            tick();
            hdr_ready = 1'b0;
        end
        checks++;
        if (hdr_valid !== 1'b0) $display("[TB] FAIL %s_empty: got %b want 0", tag, hdr_valid);
        else passes++;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pkt_count !== 0 || beat_count !== 0 || ftype_seen !== 16'h0)
            $display("[TB] FAIL reset_counts: got %0d/%0d/%h want 0/0/0000", pkt_count, beat_count, ftype_seen);
        else passes++;
        checks++;
        if (hdr_valid !== 0 || hdr_data !== 0 || hdr_tuser !== 0 || hdr_len !== 0)
            $display("[TB] FAIL reset_fifo: got %b/%h/%h/%0d want 0", hdr_valid, hdr_data, hdr_tuser, hdr_len);
        else passes++;
        checks++;
        if ({hdr_overflow, err_hold, err_stall} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b want 000", {hdr_overflow, err_hold, err_stall});
        else passes++;
    endtask

    task automatic test_basic();
        do_reset();
        send_pkt(1, 4'd2,  32'h0001_0002, 1'b1);
        send_pkt(4, 4'd5,  32'h0003_0004, 1'b1);
        send_pkt(2, 4'd13, 32'h0005_0006, 1'b1);
        checks++;
        if (pkt_count !== 3) $display("[TB] FAIL basic_pkt: got %0d want 3", pkt_count);
        else passes++;
        checks++;
        if (beat_count !== 7) $display("[TB] FAIL basic_beat: got %0d want 7", beat_count);
        else passes++;
        checks++;
        if (ftype_seen !== 16'h2024) $display("[TB] FAIL basic_ftype: got %h want 2024", ftype_seen);
        else passes++;
        drain("basic");
    endtask

    task automatic test_overflow();
        rec_t r;
        do_reset();
        for (int i = 0; i < 8; i++) send_pkt(1, 4'(i), 32'h100 + 32'(i), 1'b1);
        checks++;
        if (hdr_overflow !== 1'b0) $display("[TB] FAIL ovf_at_full: got %b want 0", hdr_overflow);
        else passes++;
        for (int i = 8; i < 10; i++) send_pkt(1, 4'(i), 32'h100 + 32'(i), 1'b0);
        checks++;
        if (hdr_valid !== 1'b1 || hdr_overflow !== 1'b1)
            $display("[TB] FAIL ovf_flag: got %b/%b want 1/1", hdr_valid, hdr_overflow);
        else passes++;
        checks++;
        if (pkt_count !== 10) $display("[TB] FAIL ovf_pkt: got %0d want 10", pkt_count);
        else passes++;
        // Pop the head on the same cycle the 11th record is pushed into the full FIFO.
        r = sb.pop_front();
        checks++;
        if (hdr_data !== r.d || hdr_tuser !== r.u)
            $display("[TB] FAIL ovf_head: got %h/%h want %h/%h", hdr_data, hdr_tuser, r.d, r.u);
        else passes++;
        hdr_ready = 1'b1;
        send_pkt(1, 4'd11, 32'h0000_0111, 1'b1);
        hdr_ready = 1'b0;
        checks++;
        if (pkt_count !== 11) $display("[TB] FAIL ovf_pkt11: got %0d want 11", pkt_count);
        else passes++;
        drain("ovf");
    endtask

    task automatic test_hold();
        do_reset();
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tdata = 64'hAAAA; tick();
        tdata = 64'hBBBB; tick(); tick();
        tready = 1'b1; tick();
        tvalid = 1'b0; tready = 1'b0; tick();
        checks++;
        if (err_hold !== 1'b1) $display("[TB] FAIL hold_data: got %b want 1", err_hold);
        else passes++;

        do_reset();
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tdata = 64'hCCCC; tick();
        tvalid = 1'b0; tick(); tick();
        checks++;
        if (err_hold !== 1'b1) $display("[TB] FAIL hold_drop: got %b want 1", err_hold);
        else passes++;

        do_reset();
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tdata = 64'hDDDD; tuser = 32'h5;
        tick(); tick(); tick();
        tready = 1'b1; tick();
        tvalid = 1'b0; tready = 1'b0; tick();
        checks++;
        if (err_hold !== 1'b0) $display("[TB] FAIL hold_clean: got %b want 0", err_hold);
        else passes++;
    endtask

    task automatic stall_then_hs(input int n);
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tdata = 64'h1234;
        repeat (n) tick();
        tready = 1'b1; tick();
        tvalid = 1'b0; tready = 1'b0; tick();
    endtask

    task automatic test_stall();
        do_reset();
        stall_then_hs(15);
        checks++;
        if (err_stall !== 1'b0) $display("[TB] FAIL stall_15: got %b want 0", err_stall);
        else passes++;
        stall_then_hs(16);
        checks++;
        if (err_stall !== 1'b1) $display("[TB] FAIL stall_16: got %b want 1", err_stall);
        else passes++;
        tick(); tick();
        checks++;
        if (err_stall !== 1'b1 || err_hold !== 1'b0)
            $display("[TB] FAIL stall_sticky: got %b/%b want 1/0", err_stall, err_hold);
        else passes++;
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(1, 4'd1, 32'h200 + 32'(i), 1'b1);
        checks++;
        if (pkt_count !== 5) $display("[TB] FAIL clr_pre: got %0d want 5", pkt_count);
        else passes++;
        clr_stats = 1'b1;
        send_pkt(1, 4'd1, 32'h0000_0205, 1'b1);
        clr_stats = 1'b0;
        checks++;
        if (pkt_count !== 0 || beat_count !== 0 || ftype_seen !== 16'h0)
            $display("[TB] FAIL clr_now: got %0d/%0d/%h want 0/0/0000", pkt_count, beat_count, ftype_seen);
        else passes++;
        tick(); tick();
        checks++;
        if (pkt_count !== 0) $display("[TB] FAIL clr_stay: got %0d want 0", pkt_count);
        else passes++;
        drain("clr");
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int b = 0; b < 2; b++) begin
            tvalid = 1'b1; tready = 1'b1; tlast = 1'b0; tdata = {$urandom, $urandom}; tuser = 32'hDEAD;
            tick();
        end
        tvalid = 1'b0;
        log_rst = 1'b1; tick(); log_rst = 1'b0;
        send_pkt(2, 4'd6, 32'h0000_0777, 1'b1);
        checks++;
        if (pkt_count !== 1 || beat_count !== 2)
            $display("[TB] FAIL rstmid_counts: got %0d/%0d want 1/2", pkt_count, beat_count);
        else passes++;
        checks++;
        if (ftype_seen !== 16'h0040) $display("[TB] FAIL rstmid_ftype: got %h want 0040", ftype_seen);
        else passes++;
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_stall();
        test_clr();
        test_rst_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
